// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver driven by an OVERSAMPLE x baud tick strobe.
//
// Recovers frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the
// asynchronous rx pin. Each good byte is placed in a holding register and
// offered with a valid/ack handshake. A low stop bit is reported as a framing
// error. A frame that completes while the holding register is still full is
// reported as an overrun.
//
// Ports
//   clk        in   1  system clock, all logic on the rising edge
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  serial line, idle high, asynchronous to clk
//   tick       in   1  1-cycle strobe at OVERSAMPLE x baud rate
//   rx_data    out  8  received byte, stable while rx_valid=1
//   rx_valid   out  1  holding register full, held until rx_ack
//   rx_ack     in   1  consumer accepts rx_data, clears rx_valid next cycle
//   rx_busy    out  1  high whenever the receiver is not idle
//   frame_err  out  1  1-cycle pulse when the stop bit is sampled low
//   overrun    out  1  sticky, set when a byte is dropped for lack of an ack
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tick,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] END_CNT = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q;
  logic               rx_s_q;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
  logic               deliver;

  // Two-flop synchronizer; both flops reset to the idle (high) line level so
  // that a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The shift register holds only payload bits; its content is meaningless
  // until eight bits have been shifted in, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;

    // An ack only means something while a byte is being offered.
    if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // React to the falling edge immediately, not on the next tick, so the
        // phase error stays within one tick.
        if (!rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end

      S_START: begin
        if (tick) begin
          if (tick_cnt_q == MID_CNT) begin
            // Mid start bit: still low means a real frame, otherwise a glitch.
            if (!rx_s_q) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == END_CNT) begin
            // A full bit period after mid start lands on mid data bit.
            shift_d    = {rx_s_q, shift_q[7:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == END_CNT) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
              deliver = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_BREAK: begin
        // Hold off until the line returns high so a long break is not
        // mistaken for a stream of start bits.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A delivery that coincides with an ack refills the register, so the
    // byte is only dropped when the old one is still unacknowledged.
    if (deliver) begin
      if (rx_valid_q && !rx_ack) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- testbench for uart_rx (OVERSAMPLE=16).
// A line driver produces 8N1 frames; a small holding-register model tracks
// what the receiver should be presenting after each frame and each ack.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tick;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int tick_per = 4;
  int fe_cnt   = 0;

  // Holding-register model
  bit         m_valid;
  bit         m_ovr;
  logic [7:0] m_data;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tick      (tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Tick strobe: one clk high every tick_per clks.
  initial begin
    int c;
    c = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      if (c >= tick_per) c = 0;
      tick = (c == 0);
    end
  end

  // Count clk cycles with frame_err high.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) fe_cnt++;
    end
  end

  function automatic void model_reset();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
  endfunction

  function automatic void model_deliver(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    else begin
      m_data  = b;
      m_valid = 1'b1;
    end
  endfunction

  function automatic void model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endfunction

  task automatic drive_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // Start bit plus 8 data bits, LSB first.
  task automatic send_head(input logic [7:0] b);
    int bc;
    bc = 16 * tick_per;
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_head(b);
    drive_bit(stop, 16 * tick_per);
    rx = 1'b1;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    model_ack();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h v=%b busy=%b fe=%b ovr=%b, want all 0",
               rx_data, rx_valid, rx_busy, frame_err, overrun);
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1);
    model_deliver(8'hA5);
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data) begin
      failures++;
      $display("FAIL basic_rx: got v=%b data=%h, want v=%b data=%h", rx_valid, rx_data, m_valid, m_data);
    end
    checks++;
    if (fe_cnt !== 0 || overrun !== 1'b0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_flags: got fe_cycles=%0d ovr=%b busy=%b, want 0 0 0", fe_cnt, overrun, rx_busy);
    end
    do_ack();
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_ack: got v=%b, want 0", rx_valid);
    end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    drive_bit(1'b0, 4 * tick_per);
    rx = 1'b1;
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy: got busy=%b, want 1", rx_busy);
    end
    repeat (64) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || overrun !== 1'b0 || fe_cnt !== fe0) begin
      failures++;
      $display("FAIL glitch_idle: got busy=%b v=%b ovr=%b fe_cycles=%0d, want 0 0 0 %0d",
               rx_busy, rx_valid, overrun, fe_cnt, fe0);
    end
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = fe_cnt;
    send_head(8'h3C);
    drive_bit(1'b0, 3 * 16 * tick_per);
    checks++;
    if (fe_cnt !== fe0 + 1 || rx_valid !== m_valid || rx_data !== m_data) begin
      failures++;
      $display("FAIL framing_err: got fe_cycles=%0d v=%b data=%h, want %0d %b %h",
               fe_cnt - fe0, rx_valid, rx_data, 1, m_valid, m_data);
    end
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL framing_break: got busy=%b, want 1 while line low", rx_busy);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL framing_release: got busy=%b, want 0", rx_busy);
    end
    send_frame(8'h81, 1'b1);
    model_deliver(8'h81);
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data) begin
      failures++;
      $display("FAIL framing_next: got v=%b data=%h, want v=%b data=%h", rx_valid, rx_data, m_valid, m_data);
    end
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    model_deliver(8'h11);
    send_frame(8'h22, 1'b1);
    model_deliver(8'h22);
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data || overrun !== m_ovr) begin
      failures++;
      $display("FAIL overrun_set: got v=%b data=%h ovr=%b, want v=%b data=%h ovr=%b",
               rx_valid, rx_data, overrun, m_valid, m_data, m_ovr);
    end
    do_ack();
    checks++;
    if (rx_valid !== m_valid || overrun !== m_ovr) begin
      failures++;
      $display("FAIL overrun_ack: got v=%b ovr=%b, want v=%b ovr=%b", rx_valid, overrun, m_valid, m_ovr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int bc;
    bc = 16 * tick_per;
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    model_deliver(b);
    // Second frame, aborted by reset in the middle of data bit 4.
    drive_bit(1'b0, bc);
    for (int i = 0; i < 4; i++) drive_bit(b[i] ^ 1'b1, bc);
    drive_bit(1'b0, bc / 2);
    checks++;
    if (rx_busy !== 1'b1 || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: got busy=%b v=%b, want 1 1", rx_busy, rx_valid);
    end
    rx = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (rx_data !== m_data || rx_valid !== m_valid || rx_busy !== 1'b0 ||
        frame_err !== 1'b0 || overrun !== m_ovr) begin
      failures++;
      $display("FAIL reset_mid: got data=%h v=%b busy=%b fe=%b ovr=%b, want all 0",
               rx_data, rx_valid, rx_busy, frame_err, overrun);
    end
    repeat (bc) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    model_deliver(8'h5A);
    checks++;
    if (rx_valid !== m_valid || rx_data !== m_data || overrun !== m_ovr) begin
      failures++;
      $display("FAIL reset_mid_next: got v=%b data=%h ovr=%b, want v=%b data=%h ovr=%b",
               rx_valid, rx_data, overrun, m_valid, m_data, m_ovr);
    end
    do_ack();
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    logic [7:0] b;
    int fe0;
    int bad;
    // Faster ticks keep the long stream short; 16 ticks per bit still holds.
    @(negedge clk);
    tick_per = 1;
    repeat (8) @(negedge clk);
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h55);
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom_range(0, 255)));
    fe0 = fe_cnt;
    bad = 0;
    while (q.size() > 0) begin
      b = q.pop_front();
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_head(b);
      checks++;
      if (rx_valid !== 1'b0) begin
        failures++;
        bad++;
        if (bad < 10) $display("FAIL loop_early: byte %h got v=%b before stop bit, want 0", b, rx_valid);
      end
      drive_bit(1'b1, 16 * tick_per);
      model_deliver(b);
      checks++;
      if (rx_valid !== m_valid || rx_data !== m_data || overrun !== m_ovr) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL loop_byte: got v=%b data=%h ovr=%b, want v=%b data=%h ovr=%b",
                   rx_valid, rx_data, overrun, m_valid, m_data, m_ovr);
      end
      do_ack();
    end
    checks++;
    if (fe_cnt !== fe0) begin
      failures++;
      $display("FAIL loop_frame_err: got fe_cycles=%0d, want 0", fe_cnt - fe0);
    end
    tick_per = 4;
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_ack = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
